laser_scan_ctrl: RTL

Sequencing controller for the laser-coverage datapath: once all points are loaded into the point store, it scans every candidate circle centre on the 16x16 grid. For each candidate it issues the point set in fixed batches to the parallel inside-evaluator/mask datapath, accumulates the returned coverage counts, and tracks the best centre. It alternates optimisation between circle 1 and circle 2 for a fixed number of iterations, then presents the two centres with a one-cycle DONE.

---
 rtl/laser_pkg.sv | 32 +++
 rtl/laser_raster_cnt.sv | 49 ++++
 rtl/laser_scan_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/laser_pkg.sv
// laser_pkg -- shared definitions for the laser-coverage scan controller.
//   state_e      : controller FSM states
//   pos_t        : packed grid position {y[3:0], x[3:0]}
//   *_DEF        : default frame/batch/iteration sizing
//   batch_cnt_w  : width of a counter that must reach OBJ_NUM/PARALLEL inclusive
package laser_pkg;

    localparam int OBJ_NUM_DEF  = 40;
    localparam int PARALLEL_DEF = 5;
    localparam int MAX_ITER_DEF = 6;
    localparam int GRID_W       = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DECIDE,
        S_OUT
    } state_e;

    typedef struct packed {
        logic [GRID_W-1:0] y;
        logic [GRID_W-1:0] x;
    } pos_t;

    // The result counter has to hold the full batch count, not just the
    // last index, so size for obj/par + 1 values.
    function automatic int batch_cnt_w(input int obj, input int par);
        return $clog2(obj / par + 1);
    endfunction

endpackage

// File: rtl/laser_raster_cnt.sv
// laser_raster_cnt -- candidate centre counter over the 16x16 grid, x fastest.
//   CLK, RST : clock, synchronous active-high reset
//   clear_i  : force position to (0,0)
//   adv_i    : step to the next raster position (wraps (15,15) -> (0,0))
//   x_o, y_o : current candidate
//   wrap_o   : current candidate is the last one, (15,15)
module laser_raster_cnt
    import laser_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              clear_i,
    input  logic              adv_i,
    output logic [GRID_W-1:0] x_o,
    output logic [GRID_W-1:0] y_o,
    output logic              wrap_o
);

    localparam logic [GRID_W-1:0] GMAX = {GRID_W{1'b1}};

    logic [GRID_W-1:0] x_q, x_d, y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (adv_i) begin
            x_d = x_q + GRID_W'(1);
            if (x_q == GMAX) y_d = y_q + GRID_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign wrap_o = (x_q == GMAX) && (y_q == GMAX);

endmodule

// File: rtl/laser_scan_ctrl.sv
// laser_scan_ctrl -- sequencing controller for the laser-coverage datapath.
// Scans every grid candidate, issues the point set in PARALLEL-sized batches,
// accumulates returned coverage counts, keeps the best centre, and alternates
// refinement between the two circles for MAX_ITER iterations.
//   CLK, RST                : clock, synchronous active-high reset
//   start                   : begin a scan (accepted only in IDLE)
//   busy, clr               : not idle / datapath mask clear pulse
//   eval_valid/ready        : batch request handshake
//   eval_base, eval_cx/cy   : batch first point index and candidate centre
//   res_valid, res_cnt      : in-order batch coverage results
//   cap_best, swap          : datapath mask capture / exchange pulses
//   C1X/C1Y/C2X/C2Y, DONE   : result centres, valid only in the DONE cycle
// Build option: define LASER_EARLY_EXIT_EN to stop after two consecutive
// iterations in which the optimised centre never changed.
module laser_scan_ctrl
    import laser_pkg::*;
#(
    parameter int OBJ_NUM  = OBJ_NUM_DEF,
    parameter int PARALLEL = PARALLEL_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    output logic       busy,
    output logic       clr,
    output logic       eval_valid,
    input  logic       eval_ready,
    output logic [5:0] eval_base,
    output logic [3:0] eval_cx,
    output logic [3:0] eval_cy,
    input  logic       res_valid,
    input  logic [2:0] res_cnt,
    output logic       cap_best,
    output logic       swap,
    output logic [3:0] C1X,
    output logic [3:0] C1Y,
    output logic [3:0] C2X,
    output logic [3:0] C2Y,
    output logic       DONE
);

    localparam int NB  = OBJ_NUM / PARALLEL;
    localparam int NBW = batch_cnt_w(OBJ_NUM, PARALLEL);
    localparam int ITW = (MAX_ITER > 1) ? $clog2(MAX_ITER + 1) : 1;

    localparam logic [NBW-1:0] LAST_BATCH = NBW'(NB - 1);
    localparam logic [NBW-1:0] ALL_RES    = NBW'(NB);
    localparam logic [ITW-1:0] LAST_ITER  = ITW'(MAX_ITER - 1);

    state_e         state_q, state_d;
    logic [NBW-1:0] batch_q, batch_d;
    logic [NBW-1:0] seen_q, seen_d, seen_nxt;
    logic [5:0]     sum_q, sum_d, sum_nxt;
    logic [5:0]     best_q, best_d;
    logic [ITW-1:0] iter_q, iter_d;
    pos_t           pos_a_q, pos_a_d, pos_b_q, pos_b_d;
    logic           clr_q, clr_d;

    logic           cand_adv, cand_clr, cand_wrap;
    logic [3:0]     cand_x, cand_y;
    pos_t           cand;
    logic           res_take, win, stop;

`ifdef LASER_EARLY_EXIT_EN
    pos_t           pos_a0_q, pos_a0_d;   // pos_a as it stood at iteration start
    logic           chg_q, chg_d, chg_nxt;
    logic           quiet_q, quiet_d;     // previous iteration ended unchanged
`endif

    laser_raster_cnt u_raster (
        .CLK     (CLK),
        .RST     (RST),
        .clear_i (cand_clr),
        .adv_i   (cand_adv),
        .x_o     (cand_x),
        .y_o     (cand_y),
        .wrap_o  (cand_wrap)
    );

    assign cand = {cand_y, cand_x};

    // Results only count while a candidate is in flight.
    assign res_take = res_valid && (state_q == S_ISSUE || state_q == S_WAIT);
    assign seen_nxt = seen_q + NBW'(res_take);
    assign sum_nxt  = sum_q + (res_take ? 6'(res_cnt) : 6'd0);
    assign win      = (sum_q >= best_q);   // ties favour the later candidate

    always_comb begin
        state_d    = state_q;
        batch_d    = batch_q;
        seen_d     = seen_q;
        sum_d      = sum_q;
        best_d     = best_q;
        iter_d     = iter_q;
        pos_a_d    = pos_a_q;
        pos_b_d    = pos_b_q;
        clr_d      = 1'b0;
        cand_adv   = 1'b0;
        cand_clr   = 1'b0;
        eval_valid = 1'b0;
        cap_best   = 1'b0;
        swap       = 1'b0;
        stop       = 1'b0;
`ifdef LASER_EARLY_EXIT_EN
        pos_a0_d   = pos_a0_q;
        chg_d      = chg_q;
        quiet_d    = quiet_q;
        chg_nxt    = chg_q | (win && (cand != pos_a0_q));
`endif

        case (state_q)
            S_IDLE: begin
                batch_d  = '0;
                seen_d   = '0;
                sum_d    = '0;
                best_d   = '0;
                iter_d   = '0;
                pos_a_d  = '0;
                pos_b_d  = '0;
                cand_clr = 1'b1;
`ifdef LASER_EARLY_EXIT_EN
                pos_a0_d = '0;
                chg_d    = 1'b0;
                quiet_d  = 1'b0;
`endif
                if (start) begin
                    state_d = S_ISSUE;
                    clr_d   = 1'b1;
                end
            end

            S_ISSUE: begin
                eval_valid = 1'b1;
                seen_d     = seen_nxt;
                sum_d      = sum_nxt;
                if (eval_ready) begin
                    if (batch_q == LAST_BATCH) begin
                        batch_d = '0;
                        // With a same-cycle result path every result may
                        // already be in; WAIT would only cost a cycle.
                        state_d = (seen_nxt == ALL_RES) ? S_DECIDE : S_WAIT;
                    end else begin
                        batch_d = batch_q + NBW'(1);
                    end
                end
            end

            S_WAIT: begin
                seen_d = seen_nxt;
                sum_d  = sum_nxt;
                if (seen_nxt == ALL_RES) state_d = S_DECIDE;
            end

            S_DECIDE: begin
                cand_adv = 1'b1;
                seen_d   = '0;
                sum_d    = '0;
                if (win) begin
                    cap_best = 1'b1;
                    best_d   = sum_q;
                    pos_a_d  = cand;
                end
`ifdef LASER_EARLY_EXIT_EN
                chg_d = chg_nxt;
`endif
                if (cand_wrap) begin
                    // Iteration end: the circle just optimised becomes the
                    // fixed one and the other circle is refined next.
                    swap    = 1'b1;
                    pos_a_d = pos_b_q;
                    pos_b_d = win ? cand : pos_a_q;
                    best_d  = '0;
                    iter_d  = iter_q + ITW'(1);
                    stop    = (iter_q == LAST_ITER);
`ifdef LASER_EARLY_EXIT_EN
                    if (!chg_nxt && quiet_q) stop = 1'b1;
                    quiet_d  = !chg_nxt;
                    chg_d    = 1'b0;
                    pos_a0_d = pos_b_q;
`endif
                    state_d = stop ? S_OUT : S_ISSUE;
                end else begin
                    state_d = S_ISSUE;
                end
            end

            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            batch_q  <= '0;
            seen_q   <= '0;
            sum_q    <= '0;
            best_q   <= '0;
            iter_q   <= '0;
            pos_a_q  <= '0;
            pos_b_q  <= '0;
            clr_q    <= 1'b0;
`ifdef LASER_EARLY_EXIT_EN
            pos_a0_q <= '0;
            chg_q    <= 1'b0;
            quiet_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            batch_q  <= batch_d;
            seen_q   <= seen_d;
            sum_q    <= sum_d;
            best_q   <= best_d;
            iter_q   <= iter_d;
            pos_a_q  <= pos_a_d;
            pos_b_q  <= pos_b_d;
            clr_q    <= clr_d;
`ifdef LASER_EARLY_EXIT_EN
            pos_a0_q <= pos_a0_d;
            chg_q    <= chg_d;
            quiet_q  <= quiet_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign clr       = clr_q;
    assign DONE      = (state_q == S_OUT);
    assign eval_base = 6'(int'(batch_q) * PARALLEL);
    assign eval_cx   = cand_x;
    assign eval_cy   = cand_y;
    assign C1X       = DONE ? pos_a_q.x : 4'd0;
    assign C1Y       = DONE ? pos_a_q.y : 4'd0;
    assign C2X       = DONE ? pos_b_q.x : 4'd0;
    assign C2Y       = DONE ? pos_b_q.y : 4'd0;

endmodule
